// File: rtl/id_stage_hs_if.sv
// rtl/id_stage_hs_if.sv - fetch/decode/execute/writeback signal bundle for id_stage_hs
// master = pipeline environment, slave = decode stage.
interface id_stage_hs_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            fs_valid;
  logic [31:0]     fs_instr;
  logic [XLEN-1:0] fs_pc;
  logic            ds_allowin;
  logic            es_allowin;
  logic            ds_to_es_valid;
  logic [31:0]     ds_instr;
  logic [XLEN-1:0] ds_pc;
  logic [XLEN-1:0] ds_rdata1;
  logic [XLEN-1:0] ds_rdata2;
  logic [AW-1:0]   ds_rd;
  logic            es_valid;
  logic            es_we;
  logic            es_is_load;
  logic [AW-1:0]   es_rd;
  logic [XLEN-1:0] es_result;
  logic            ms_valid;
  logic            ms_we;
  logic [AW-1:0]   ms_rd;
  logic [XLEN-1:0] ms_result;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic            br_taken;
  logic [XLEN-1:0] br_target;

  modport master (
    output fs_valid, fs_instr, fs_pc, es_allowin,
    output es_valid, es_we, es_is_load, es_rd, es_result,
    output ms_valid, ms_we, ms_rd, ms_result,
    output wb_we, wb_rd, wb_wdata,
    input  ds_allowin, ds_to_es_valid, ds_instr, ds_pc,
    input  ds_rdata1, ds_rdata2, ds_rd, br_taken, br_target
  );

  modport slave (
    input  fs_valid, fs_instr, fs_pc, es_allowin,
    input  es_valid, es_we, es_is_load, es_rd, es_result,
    input  ms_valid, ms_we, ms_rd, ms_result,
    input  wb_we, wb_rd, wb_wdata,
    output ds_allowin, ds_to_es_valid, ds_instr, ds_pc,
    output ds_rdata1, ds_rdata2, ds_rd, br_taken, br_target
  );
endinterface

// File: rtl/id_stage_hs.sv
// rtl/id_stage_hs.sv - decode stage: FS->DS latch, regfile, RAW interlock, branch resolution
// Define ID_FWD_EN to forward EX/MEM results instead of stalling on them.
module id_stage_hs #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  id_stage_hs_if.slave io_bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;

  logic            r_ds_valid;
  logic [31:0]     r_ds_instr;
  logic [XLEN-1:0] r_ds_pc;
  logic [XLEN-1:0] r_rf [NREG];

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [AW-1:0]   w_rs1, w_rs2;
  logic            w_uses1, w_uses2;
  logic            w_es_m1, w_es_m2, w_ms_m1, w_ms_m2, w_wb_m1, w_wb_m2;
  logic [XLEN-1:0] w_base1, w_base2, w_rdata1, w_rdata2;
  logic            w_hz1, w_hz2, w_stall, w_ready_go, w_ds_allowin;
  logic            w_is_store, w_is_branch, w_cond, w_br_taken;
  logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_j, w_br_target;

  assign w_opcode    = r_ds_instr[6:0];
  assign w_funct3    = r_ds_instr[14:12];
  assign w_rs1       = AW'(r_ds_instr[19:15]);
  assign w_rs2       = AW'(r_ds_instr[24:20]);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_uses1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
  assign w_uses2 = (w_opcode == OP_R) || w_is_store || w_is_branch;

  // x0 never matches a producer, so it can neither stall nor be forwarded.
  assign w_es_m1 = io_bus.es_valid & io_bus.es_we & (io_bus.es_rd == w_rs1) & (w_rs1 != '0);
  assign w_es_m2 = io_bus.es_valid & io_bus.es_we & (io_bus.es_rd == w_rs2) & (w_rs2 != '0);
  assign w_ms_m1 = io_bus.ms_valid & io_bus.ms_we & (io_bus.ms_rd == w_rs1) & (w_rs1 != '0);
  assign w_ms_m2 = io_bus.ms_valid & io_bus.ms_we & (io_bus.ms_rd == w_rs2) & (w_rs2 != '0);
  assign w_wb_m1 = io_bus.wb_we & (io_bus.wb_rd == w_rs1) & (w_rs1 != '0);
  assign w_wb_m2 = io_bus.wb_we & (io_bus.wb_rd == w_rs2) & (w_rs2 != '0);

  assign w_base1 = w_wb_m1 ? io_bus.wb_wdata : ((w_rs1 == '0) ? '0 : r_rf[w_rs1]);
  assign w_base2 = w_wb_m2 ? io_bus.wb_wdata : ((w_rs2 == '0) ? '0 : r_rf[w_rs2]);

`ifdef ID_FWD_EN
  assign w_rdata1 = w_es_m1 ? io_bus.es_result : (w_ms_m1 ? io_bus.ms_result : w_base1);
  assign w_rdata2 = w_es_m2 ? io_bus.es_result : (w_ms_m2 ? io_bus.ms_result : w_base2);
  assign w_hz1    = w_es_m1 & io_bus.es_is_load;
  assign w_hz2    = w_es_m2 & io_bus.es_is_load;
`else
  assign w_rdata1 = w_base1;
  assign w_rdata2 = w_base2;
  assign w_hz1    = w_es_m1 | w_ms_m1;
  assign w_hz2    = w_es_m2 | w_ms_m2;
`endif

  assign w_stall      = (w_uses1 & w_hz1) | (w_uses2 & w_hz2);
  assign w_ready_go   = !w_stall;
  assign w_ds_allowin = !r_ds_valid | (w_ready_go & io_bus.es_allowin);

  always_comb begin
    w_cond = 1'b0;
    if ((w_opcode == OP_JAL) || (w_opcode == OP_JALR)) begin
      w_cond = 1'b1;
    end else if (w_is_branch) begin
      case (w_funct3)
        3'b000:  w_cond = (w_rdata1 == w_rdata2);
        3'b001:  w_cond = (w_rdata1 != w_rdata2);
        3'b100:  w_cond = ($signed(w_rdata1) <  $signed(w_rdata2));
        3'b101:  w_cond = ($signed(w_rdata1) >= $signed(w_rdata2));
        3'b110:  w_cond = (w_rdata1 <  w_rdata2);
        3'b111:  w_cond = (w_rdata1 >= w_rdata2);
        default: w_cond = 1'b0;
      endcase
    end
  end

  assign w_imm_i = {{(XLEN-12){r_ds_instr[31]}}, r_ds_instr[31:20]};
  assign w_imm_b = {{(XLEN-13){r_ds_instr[31]}}, r_ds_instr[31], r_ds_instr[7],
                    r_ds_instr[30:25], r_ds_instr[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-21){r_ds_instr[31]}}, r_ds_instr[31], r_ds_instr[19:12],
                    r_ds_instr[20], r_ds_instr[30:21], 1'b0};

  always_comb begin
    w_br_target = r_ds_pc + w_imm_b;
    if (w_opcode == OP_JAL) begin
      w_br_target = r_ds_pc + w_imm_j;
    end else if (w_opcode == OP_JALR) begin
      w_br_target = (w_rdata1 + w_imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
    end
  end

  // Redirect only fires on the cycle the instruction actually leaves DS.
  assign w_br_taken = r_ds_valid & w_ready_go & io_bus.es_allowin & w_cond;

  assign io_bus.ds_allowin     = w_ds_allowin;
  assign io_bus.ds_to_es_valid = r_ds_valid & w_ready_go;
  assign io_bus.ds_instr       = r_ds_instr;
  assign io_bus.ds_pc          = r_ds_pc;
  assign io_bus.ds_rdata1      = w_rdata1;
  assign io_bus.ds_rdata2      = w_rdata2;
  assign io_bus.ds_rd          = (w_is_store | w_is_branch) ? '0 : AW'(r_ds_instr[11:7]);
  assign io_bus.br_taken       = w_br_taken;
  assign io_bus.br_target      = w_br_target;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ds_valid <= 1'b0;
      r_ds_instr <= '0;
      r_ds_pc    <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (w_ds_allowin) begin
        r_ds_valid <= io_bus.fs_valid & ~w_br_taken;
      end
      if (w_ds_allowin & io_bus.fs_valid) begin
        r_ds_instr <= io_bus.fs_instr;
        r_ds_pc    <= io_bus.fs_pc;
      end
      if (io_bus.wb_we && (io_bus.wb_rd != '0)) begin
        r_rf[io_bus.wb_rd] <= io_bus.wb_wdata;
      end
    end
  end
endmodule

// File: tb/tb_id_stage_hs.sv
// tb/tb_id_stage_hs.sv - directed and random bench for id_stage_hs against a record-level model
module tb_id_stage_hs;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;
`ifdef ID_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    int          kind;
    int          rd;
    int          rs1;
    int          rs2;
    int          f3;
    logic [31:0] imm;
  } rec_t;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail = 0;

  rec_t        cur_rec, m_rec;
  logic        m_valid;
  logic [31:0] m_instr, m_pc;
  logic [31:0] m_rf [32];
  logic        e_allowin, e_br;

  always #5 clk = ~clk;

  id_stage_hs_if #(.XLEN(32), .AW(5)) bus ();

  id_stage_hs #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .io_bus   (bus)
  );

  function automatic rec_t mk(int kind, int rd, int rs1, int rs2, int f3, logic [31:0] imm);
    rec_t r;
    r.kind = kind; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.imm = imm;
    return r;
  endfunction

  function automatic logic [31:0] enc(rec_t r);
    logic [4:0]  rd, s1, s2;
    logic [2:0]  f3;
    logic [31:0] im;
    rd = 5'(r.rd); s1 = 5'(r.rs1); s2 = 5'(r.rs2); f3 = 3'(r.f3); im = r.imm;
    case (r.kind)
      K_R:     return {7'b0, s2, s1, 3'b000, rd, 7'h33};
      K_I:     return {im[11:0], s1, 3'b000, rd, 7'h13};
      K_LD:    return {im[11:0], s1, 3'b010, rd, 7'h03};
      K_ST:    return {im[11:5], s2, s1, 3'b010, im[4:0], 7'h23};
      K_BR:    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
      K_JAL:   return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
      K_JALR:  return {im[11:0], s1, 3'b000, rd, 7'h67};
      K_LUI:   return {im[19:0], rd, 7'h37};
      default: return {im[19:0], rd, 7'h17};
    endcase
  endfunction

  function automatic rec_t rnd_rec();
    rec_t        r;
    int          f3s [6] = '{0, 1, 4, 5, 6, 7};
    logic [11:0] t12;
    logic [12:0] t13;
    logic [20:0] t21;
    r.kind = int'($urandom_range(0, 8));
    r.rd   = int'($urandom_range(0, 7));
    r.rs1  = int'($urandom_range(0, 7));
    r.rs2  = int'($urandom_range(0, 7));
    r.f3   = f3s[$urandom_range(0, 5)];
    t12 = 12'($urandom);
    t13 = 13'($urandom) & 13'h1ffe;
    t21 = 21'($urandom) & 21'h1ffffe;
    case (r.kind)
      K_BR:             r.imm = {{19{t13[12]}}, t13};
      K_JAL:            r.imm = {{11{t21[20]}}, t21};
      K_LUI, K_AUIPC:   r.imm = $urandom & 32'h000f_ffff;
      default:          r.imm = {{20{t12[11]}}, t12};
    endcase
    return r;
  endfunction

  function automatic bit reads1(rec_t r);
    return !(r.kind == K_LUI || r.kind == K_AUIPC || r.kind == K_JAL);
  endfunction

  function automatic bit reads2(rec_t r);
    return (r.kind == K_R || r.kind == K_ST || r.kind == K_BR);
  endfunction

  function automatic bit ex_hit(int rs);
    return rs != 0 && bus.es_valid && bus.es_we && int'(bus.es_rd) == rs;
  endfunction

  function automatic bit mem_hit(int rs);
    return rs != 0 && bus.ms_valid && bus.ms_we && int'(bus.ms_rd) == rs;
  endfunction

  function automatic logic [31:0] opnd(int rs);
    if (rs == 0) return 32'h0;
    if (FWD && ex_hit(rs)) return bus.es_result;
    if (FWD && mem_hit(rs)) return bus.ms_result;
    if (bus.wb_we && int'(bus.wb_rd) == rs) return bus.wb_wdata;
    return m_rf[rs];
  endfunction

  function automatic bit blocked(int rs);
    if (FWD) return ex_hit(rs) && bus.es_is_load;
    return ex_hit(rs) || mem_hit(rs);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
    m_rec = mk(K_I, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  task automatic idle();
    bus.fs_valid = 1'b0; bus.fs_instr = 32'h0; bus.fs_pc = 32'h0; bus.es_allowin = 1'b1;
    bus.es_valid = 1'b0; bus.es_we = 1'b0; bus.es_is_load = 1'b0; bus.es_rd = 5'd0; bus.es_result = 32'h0;
    bus.ms_valid = 1'b0; bus.ms_we = 1'b0; bus.ms_rd = 5'd0; bus.ms_result = 32'h0;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_wdata = 32'h0;
  endtask

  task automatic offer(rec_t r, logic [31:0] pc);
    cur_rec = r; bus.fs_valid = 1'b1; bus.fs_instr = enc(r); bus.fs_pc = pc;
  endtask

  // Evaluate the model against the current inputs and compare every output.
  task automatic sample(string tag);
    bit          stall, go, cond;
    logic [31:0] a, b, tgt, exp_rd;
    #2;
    a = opnd(m_rec.rs1);
    b = opnd(m_rec.rs2);
    stall = (reads1(m_rec) && blocked(m_rec.rs1)) || (reads2(m_rec) && blocked(m_rec.rs2));
    go = m_valid && !stall;
    case (m_rec.kind)
      K_JAL, K_JALR: cond = 1'b1;
      K_BR: case (m_rec.f3)
        0: cond = (a == b);
        1: cond = (a != b);
        4: cond = ($signed(a) < $signed(b));
        5: cond = ($signed(a) >= $signed(b));
        6: cond = (a < b);
        default: cond = (a >= b);
      endcase
      default: cond = 1'b0;
    endcase
    tgt = (m_rec.kind == K_JALR) ? ((a + m_rec.imm) & ~32'h1) : (m_pc + m_rec.imm);
    exp_rd = (m_rec.kind == K_ST || m_rec.kind == K_BR) ? 32'h0 : 32'(m_rec.rd);
    e_allowin = !m_valid || (go && bus.es_allowin);
    e_br = go && bus.es_allowin && cond;
    chk({tag, ".allowin"}, 32'(bus.ds_allowin), 32'(e_allowin));
    chk({tag, ".to_es_valid"}, 32'(bus.ds_to_es_valid), 32'(go));
    chk({tag, ".br_taken"}, 32'(bus.br_taken), 32'(e_br));
    chk({tag, ".instr"}, bus.ds_instr, m_instr);
    chk({tag, ".pc"}, bus.ds_pc, m_pc);
    chk({tag, ".rd"}, 32'(bus.ds_rd), exp_rd);
    if (go && reads1(m_rec)) chk({tag, ".rdata1"}, bus.ds_rdata1, a);
    if (go && reads2(m_rec)) chk({tag, ".rdata2"}, bus.ds_rdata2, b);
    if (e_br) chk({tag, ".target"}, bus.br_target, tgt);
  endtask

  task automatic advance();
    @(posedge clk);
    if (e_allowin) begin
      m_valid = bus.fs_valid && !e_br;
      if (bus.fs_valid) begin
        m_rec = cur_rec; m_instr = bus.fs_instr; m_pc = bus.fs_pc;
      end
    end
    if (bus.wb_we && bus.wb_rd != 5'd0) m_rf[bus.wb_rd] = bus.wb_wdata;
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    model_reset();
    cur_rec = m_rec;
    #1;
    sample("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Writeback bypass in the same cycle as the read.
    idle(); offer(mk(K_R, 1, 3, 0, 0, 0), 32'h40); sample("wb_load"); advance();
    idle(); bus.wb_we = 1; bus.wb_rd = 3; bus.wb_wdata = 32'hdead_beef;
    sample("wb_thru"); chk("wb_thru_lit", bus.ds_rdata1, 32'hdead_beef); advance();

    // RAW against an ALU producer in EX, then following it down the pipe.
    idle(); offer(mk(K_I, 4, 2, 0, 0, 32'h1), 32'h80); sample("raw_load"); advance();
    idle(); bus.es_valid = 1; bus.es_we = 1; bus.es_rd = 2; bus.es_result = 32'h10;
    sample("raw_ex");
`ifdef ID_FWD_EN
    chk("raw_ex_fwd_go", 32'(bus.ds_to_es_valid), 32'h1);
    chk("raw_ex_fwd_data", bus.ds_rdata1, 32'h10);
`else
    chk("raw_ex_stall_allowin", 32'(bus.ds_allowin), 32'h0);
    chk("raw_ex_stall_go", 32'(bus.ds_to_es_valid), 32'h0);
`endif
    advance();
    idle(); bus.ms_valid = 1; bus.ms_we = 1; bus.ms_rd = 2; bus.ms_result = 32'h10;
    sample("raw_ms");
`ifndef ID_FWD_EN
    chk("raw_ms_stall_allowin", 32'(bus.ds_allowin), 32'h0);
`endif
    advance();
    idle(); bus.wb_we = 1; bus.wb_rd = 2; bus.wb_wdata = 32'h10;
    sample("raw_wb");
`ifndef ID_FWD_EN
    chk("raw_wb_go", 32'(bus.ds_to_es_valid), 32'h1);
    chk("raw_wb_data", bus.ds_rdata1, 32'h10);
`endif
    advance();

    // Load-use on x7.
    idle(); offer(mk(K_R, 8, 7, 0, 0, 0), 32'hc0); sample("lu_load"); advance();
    idle(); bus.es_valid = 1; bus.es_we = 1; bus.es_is_load = 1; bus.es_rd = 7;
    sample("lu_ex"); chk("lu_ex_stall", 32'(bus.ds_to_es_valid), 32'h0); advance();
    idle(); bus.ms_valid = 1; bus.ms_we = 1; bus.ms_rd = 7; bus.ms_result = 32'h77;
    sample("lu_ms");
`ifdef ID_FWD_EN
    chk("lu_ms_go", 32'(bus.ds_to_es_valid), 32'h1);
    chk("lu_ms_data", bus.ds_rdata1, 32'h77);
`else
    chk("lu_ms_stall", 32'(bus.ds_to_es_valid), 32'h0);
`endif
    advance();
    idle(); bus.wb_we = 1; bus.wb_rd = 7; bus.wb_wdata = 32'h77; sample("lu_wb"); advance();

    // Taken BEQ squashes the next fetch; JALR target clears bit 0.
    idle(); offer(mk(K_BR, 0, 1, 1, 0, 32'h20), 32'h100); sample("beq_load"); advance();
    idle(); offer(mk(K_I, 5, 6, 0, 0, 32'h3), 32'h104);
    sample("beq"); chk("beq_taken", 32'(bus.br_taken), 32'h1); chk("beq_target", bus.br_target, 32'h120);
    advance();
    idle(); sample("beq_squash"); chk("beq_squash_lit", 32'(bus.ds_to_es_valid), 32'h0); advance();
    idle(); offer(mk(K_JALR, 1, 5, 0, 0, 32'h4), 32'h140); sample("jalr_load"); advance();
    idle(); bus.wb_we = 1; bus.wb_rd = 5; bus.wb_wdata = 32'h203;
    sample("jalr"); chk("jalr_target", bus.br_target, 32'h206); advance();

    // Backpressure holds a taken branch, then exactly one pulse.
    idle(); offer(mk(K_BR, 0, 0, 0, 0, 32'hffff_fff8), 32'h180); sample("bp_load"); advance();
    for (int i = 0; i < 2; i++) begin
      idle(); bus.es_allowin = 0; sample("bp_hold");
      chk("bp_hold_br", 32'(bus.br_taken), 32'h0); advance();
    end
    idle(); sample("bp_go"); chk("bp_go_br", 32'(bus.br_taken), 32'h1);
    chk("bp_go_target", bus.br_target, 32'h178); advance();
    idle(); sample("bp_after"); chk("bp_after_br", 32'(bus.br_taken), 32'h0); advance();

    // Asynchronous reset with a taken JAL in DS; x5 must read zero afterwards.
    idle(); offer(mk(K_JAL, 1, 0, 0, 0, 32'h40), 32'h200); sample("rst_load"); advance();
    idle(); sample("rst_pre");
    resetn = 1'b0; model_reset(); #1;
    chk("rst_async_go", 32'(bus.ds_to_es_valid), 32'h0);
    chk("rst_async_br", 32'(bus.br_taken), 32'h0);
    @(posedge clk); #1; resetn = 1'b1;
    idle(); offer(mk(K_R, 9, 5, 0, 0, 0), 32'h300); sample("rst_x5_load"); advance();
    idle(); sample("rst_x5"); chk("rst_x5_zero", bus.ds_rdata1, 32'h0); advance();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      cur_rec = rnd_rec();
      bus.fs_valid = ($urandom_range(0, 9) < 7);
      bus.fs_instr = enc(cur_rec);
      bus.fs_pc = $urandom & ~32'h3;
      bus.es_allowin = ($urandom_range(0, 9) < 8);
      bus.es_valid = 1'($urandom); bus.es_we = 1'($urandom); bus.es_is_load = 1'($urandom);
      bus.es_rd = 5'($urandom_range(0, 7)); bus.es_result = $urandom;
      bus.ms_valid = 1'($urandom); bus.ms_we = 1'($urandom);
      bus.ms_rd = 5'($urandom_range(0, 7)); bus.ms_result = $urandom;
      bus.wb_we = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 7)); bus.wb_wdata = $urandom;
      sample("rnd");
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
